// File: rtl/dm_port_sched.sv
// dm_port_sched: arbitrates the single data-memory port between issued loads and an in-order committed-store buffer.
// Loads win unless the buffer is full, stores have starved, or the load overlaps a buffered/enqueuing store word.
module dm_port_sched #(
   parameter int SB_DEPTH   = 4,
   parameter int STARVE_MAX = 3,
   parameter int ROB_W      = 6
) (
   input  logic                            CLK,
   input  logic                            RESET,
   input  logic                            FREEZE,
   input  logic                            ld_valid,
   input  logic [31:0]                     ld_addr,
   input  logic [ROB_W-1:0]                ld_rob,
   output logic                            ld_ready,
   input  logic                            st_valid,
   input  logic [31:0]                     st_addr,
   input  logic [31:0]                     st_data,
   output logic                            st_ready,
   output logic [31:0]                     dm_addr,
   output logic [31:0]                     dm_wdata,
   output logic                            dm_read,
   output logic                            dm_write,
   input  logic [31:0]                     dm_rdata,
   output logic                            ld_resp_valid,
   output logic [31:0]                     ld_resp_data,
   output logic [ROB_W-1:0]                ld_resp_rob,
   output logic [$clog2(SB_DEPTH+1)-1:0]   sb_count,
   output logic                            sb_empty
);
   localparam int PW = $clog2(SB_DEPTH);
   localparam int CW = $clog2(SB_DEPTH+1);
   localparam int SW = $clog2(STARVE_MAX+1);
   logic [31:0]      addr_q [SB_DEPTH];
   logic [31:0]      data_q [SB_DEPTH];
   logic [PW-1:0]    head_q, tail_q, off;
   logic [CW-1:0]    count_q, count_d;
   logic [SW-1:0]    starve_q, starve_d;
   logic             resp_valid_q;
   logic [31:0]      resp_data_q;
   logic [ROB_W-1:0] resp_rob_q;
   logic             active, empty, force_st, conflict, enq, ld_grant, st_grant;
   always_comb begin
      active   = !RESET && !FREEZE;
      empty    = count_q == '0;
      st_ready = active && count_q < CW'(SB_DEPTH);
      enq      = st_valid && st_ready;
      force_st = count_q == CW'(SB_DEPTH) || (starve_q == SW'(STARVE_MAX) && !empty);
      conflict = enq && st_addr[31:2] == ld_addr[31:2];
      off      = '0;
      // an entry is live when its distance from head is below the count
      for (int i = 0; i < SB_DEPTH; i++) begin
         off = PW'(i) - head_q;
         if (CW'(off) < count_q && addr_q[i][31:2] == ld_addr[31:2]) conflict = 1'b1;
      end
      ld_grant = active && ld_valid && !conflict && !force_st;
      st_grant = active && !empty && !ld_grant;
      ld_ready = ld_grant;
      dm_read  = ld_grant;
      dm_write = st_grant;
      dm_addr  = ld_grant ? ld_addr : st_grant ? addr_q[head_q] : '0;
      dm_wdata = st_grant ? data_q[head_q] : '0;
      count_d  = count_q + CW'(enq) - CW'(st_grant);
      starve_d = st_grant || (ld_grant && empty) ? '0 :
                 ld_grant && starve_q != SW'(STARVE_MAX) ? starve_q + SW'(1) : starve_q;
      sb_count = count_q;
      sb_empty = empty;
      ld_resp_valid = resp_valid_q;
      ld_resp_data  = resp_data_q;
      ld_resp_rob   = resp_rob_q;
   end
   always_ff @(posedge CLK) begin
      if (RESET) begin
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         starve_q     <= '0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_rob_q   <= '0;
      end else if (!FREEZE) begin
         if (enq) begin
            addr_q[tail_q] <= st_addr;
            data_q[tail_q] <= st_data;
            tail_q         <= tail_q + PW'(1);
         end
         if (st_grant) head_q <= head_q + PW'(1);
         count_q      <= count_d;
         starve_q     <= starve_d;
         resp_valid_q <= ld_grant;
         if (ld_grant) begin
            resp_data_q <= dm_rdata;
            resp_rob_q  <= ld_rob;
         end
      end
   end
endmodule
